// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
// Multicycle processor control unit: sequences FETCH/DECODE/EXEC/MEM/WB for a
// 16-bit ISA, drives the datapath strobes, counts retired instructions and
// traps on illegal opcodes or a data-memory handshake that never completes.
module multicycle_ctrl #(
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [2:0]       state,
  output logic             busy,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6,
    BAD    = 3'd7
  } state_e;

  localparam int WAIT_W = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TMO - 1);

  state_e             state_q, state_d;
  logic               stop_q, stop_d;
  logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic               retire;
  logic               isLw, isSw, isRtype, isBeq, isBne, isJmp, isIllegal;

  // Opcode classes shared by the sequencing and the strobe decode.
  always_comb begin
    isLw      = (opcode == 4'b0000);
    isSw      = (opcode == 4'b0001);
    isRtype   = (opcode >= 4'b0010) && (opcode <= 4'b1001);
    isBeq     = (opcode == 4'b1011);
    isBne     = (opcode == 4'b1100);
    isJmp     = (opcode == 4'b1101);
    isIllegal = (opcode == 4'b1010) || (opcode == 4'b1110) || (opcode == 4'b1111);
  end

  // Next-state sequencing; every retire funnels through one point so the stop request is honoured uniformly.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        if (isIllegal) begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (isRtype) begin
          state_d = WB;
        end else if (isLw || isSw) begin
          state_d   = MEM;
          waitCnt_d = '0;
        end else if (isBeq || isBne || isJmp) begin
          retire = 1'b1;
        end else begin
          // Opcode changed to an illegal value after DECODE: treat it as illegal.
          state_d   = TRAP;
          illegal_d = 1'b1;
        end
      end
      MEM: begin
        if (mem_ready) begin
          if (isLw) state_d = WB;
          else      retire  = 1'b1;
        end else if (waitCnt_q == WAIT_LAST) begin
          state_d   = TRAP;
          timeout_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
      end
      WB: begin
        retire = 1'b1;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase
    if (retire) state_d = (stop || stop_q) ? IDLE : FETCH;
    retired_d = retired_q + CNT_W'(retire);
    if (state_d == IDLE)      stop_d = 1'b0;
    else if (busy && stop)    stop_d = 1'b1;
    else                      stop_d = stop_q;
  end

  // State, stop latch, wait counter, retire counter and sticky trap causes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stop_q    <= 1'b0;
      waitCnt_q <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stop_q    <= stop_d;
      waitCnt_q <= waitCnt_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Datapath strobes and selects decoded from the current state and opcode; everything idles at 0.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        pc_src   = 2'b00;
      end
      EXEC: begin
        if (isLw || isSw) begin
          alu_op  = 2'b10;
          alu_src = 1'b1;
        end else if (isBeq || isBne) begin
          alu_op   = 2'b01;
          pc_src   = 2'b01;
          pc_write = isBeq ? zero : ~zero;
        end else if (isJmp) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
      end
      MEM: begin
        mem_read  = isLw;
        mem_write = isSw;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = isRtype;
        mem_to_reg = isLw;
      end
      default: begin
      end
    endcase
  end

  assign state   = state_q;
  assign busy    = (state_q != IDLE) && (state_q != TRAP);
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams, each judged against a phase-list model of the ISA.
module tb_multicycle_ctrl;

  localparam int CNT_W   = 4;
  localparam int MEM_TMO = 15;
  localparam int NEVER   = 1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [3:0]       opcode = 4'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             pc_write, ir_write, mem_read, mem_write, reg_write;
  logic             alu_src, reg_dst, mem_to_reg;
  logic [1:0]       alu_op, pc_src;
  logic [2:0]       state;
  logic             busy, illegal, timeout;
  logic [CNT_W-1:0] retired;
  logic [11:0]      strobes;

  int               nAssert = 0;
  int               nFail = 0;
  int               expState = 0;
  logic [CNT_W-1:0] expRetired = '0;
  logic [3:0]       legalOps [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                      4'd7, 4'd8, 4'd9, 4'd11, 4'd12, 4'd13};

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .pc_src(pc_src), .state(state), .busy(busy),
    .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  assign strobes = {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src,
                    reg_dst, mem_to_reg, alu_op, pc_src};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic [3:0] op,
                               input logic z, input logic mr);
    start     = st;
    stop      = sp;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    checkOutput("rstState", 32'(state), 32'd0);
    checkOutput("rstRetired", 32'(retired), 32'd0);
    checkOutput("rstIllegal", 32'(illegal), 32'd0);
    checkOutput("rstTimeout", 32'(timeout), 32'd0);
    checkOutput("rstStrobes", 32'(strobes), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n      = 1'b1;
    expState   = 0;
    expRetired = '0;
  endtask

  // One instruction from FETCH to its retire or trap, compared against the phase list the ISA implies.
  task automatic runInstr(input logic [3:0] op, input logic z, input int waits, input int stopCyc);
    int phases[$];
    bit isLw, isSw, isR, isBeq, isBne, isJ, isIll, isTmo, taken, stopSeen;
    int nMem, expEnd;
    int cIr = 0, cPcSeq = 0, cPcBr = 0, cPcJmp = 0, cPcAll = 0, cRd = 0, cWr = 0;
    int cRegW = 0, cRegDst = 0, cMemToReg = 0, cAluBr = 0, cAluMem = 0, cAluSrc = 0, cBusy = 0;
    isLw  = (op == 4'd0);
    isSw  = (op == 4'd1);
    isR   = (op >= 4'd2) && (op <= 4'd9);
    isBeq = (op == 4'd11);
    isBne = (op == 4'd12);
    isJ   = (op == 4'd13);
    isIll = (op == 4'd10) || (op == 4'd14) || (op == 4'd15);
    isTmo = (isLw || isSw) && (waits >= MEM_TMO);
    taken = isJ || (isBeq && z) || (isBne && !z);
    nMem  = isTmo ? MEM_TMO : waits + 1;
    phases = {1, 2};
    if (!isIll) begin
      phases.push_back(3);
      if (isLw || isSw) for (int i = 0; i < nMem; i++) phases.push_back(4);
      if (isR || (isLw && !isTmo)) phases.push_back(5);
    end
    stopSeen = (stopCyc >= 0) && (stopCyc < phases.size());
    for (int c = 0; c < phases.size(); c++) begin
      applyStimulus(1'($urandom_range(0, 1)), (c == stopCyc), op, z, (c >= 3 + waits));
      #1;
      checkOutput($sformatf("state[%0d] op%0d", c, op), 32'(state), 32'(phases[c]));
      cIr       += int'(ir_write);
      cPcSeq    += int'(pc_write && pc_src == 2'b00);
      cPcBr     += int'(pc_write && pc_src == 2'b01);
      cPcJmp    += int'(pc_write && pc_src == 2'b10);
      cPcAll    += int'(pc_write);
      cRd       += int'(mem_read);
      cWr       += int'(mem_write);
      cRegW     += int'(reg_write);
      cRegDst   += int'(reg_dst);
      cMemToReg += int'(mem_to_reg);
      cAluBr    += int'(alu_op == 2'b01);
      cAluMem   += int'(alu_op == 2'b10);
      cAluSrc   += int'(alu_src);
      cBusy     += int'(busy);
      tick();
    end
    applyStimulus(1'b0, 1'b0, op, z, 1'b0);
    expEnd = (isIll || isTmo) ? 6 : (stopSeen ? 0 : 1);
    if (!(isIll || isTmo)) expRetired = expRetired + CNT_W'(1);
    #1;
    checkOutput($sformatf("endState op%0d", op), 32'(state), 32'(expEnd));
    checkOutput("retired", 32'(retired), 32'(expRetired));
    checkOutput("illegalFlag", 32'(illegal), 32'(isIll));
    checkOutput("timeoutFlag", 32'(timeout), 32'(isTmo));
    checkOutput("irWriteCycles", 32'(cIr), 32'd1);
    checkOutput("pcSeqCycles", 32'(cPcSeq), 32'd1);
    checkOutput("pcBranchCycles", 32'(cPcBr), 32'((isBeq || isBne) && taken));
    checkOutput("pcJumpCycles", 32'(cPcJmp), 32'(isJ));
    checkOutput("pcWriteCycles", 32'(cPcAll), 32'(1 + int'(taken)));
    checkOutput("memReadCycles", 32'(cRd), 32'(isLw ? nMem : 0));
    checkOutput("memWriteCycles", 32'(cWr), 32'(isSw ? nMem : 0));
    checkOutput("regWriteCycles", 32'(cRegW), 32'(isR || (isLw && !isTmo)));
    checkOutput("regDstCycles", 32'(cRegDst), 32'(isR));
    checkOutput("memToRegCycles", 32'(cMemToReg), 32'(isLw && !isTmo));
    checkOutput("aluBranchCycles", 32'(cAluBr), 32'(isBeq || isBne));
    checkOutput("aluMemCycles", 32'(cAluMem), 32'(isLw || isSw));
    checkOutput("aluSrcCycles", 32'(cAluSrc), 32'(isLw || isSw));
    checkOutput("busyCycles", 32'(cBusy), 32'(phases.size()));
    expState = expEnd;
  endtask

  // Bring the controller to FETCH (resetting out of TRAP, starting out of IDLE) and run one instruction.
  task automatic nextInstr(input logic [3:0] op, input logic z, input int waits, input int stopCyc);
    if (expState == 6) doReset();
    if (expState == 0) begin
      applyStimulus(1'b1, 1'b0, op, z, 1'b0);
      tick();
    end
    runInstr(op, z, waits, stopCyc);
  endtask

  // TRAP must ignore start/stop and keep every strobe low.
  task automatic trapHold(input logic expIll, input logic expTmo);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      checkOutput("trapState", 32'(state), 32'd6);
      checkOutput("trapStrobes", 32'(strobes), 32'd0);
      checkOutput("trapBusy", 32'(busy), 32'd0);
      checkOutput("trapRetired", 32'(retired), 32'(expRetired));
      checkOutput("trapIllegal", 32'(illegal), 32'(expIll));
      checkOutput("trapTimeout", 32'(timeout), 32'(expTmo));
      tick();
    end
  endtask

  // Linear directed scenarios followed by a randomized instruction stream.
  initial begin
    #2;
    doReset();

    // IDLE holds without start, and stop there is not remembered.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
      #1;
      checkOutput("idleHold", 32'(state), 32'd0);
      tick();
    end

    $display("[TB] directed instructions");
    nextInstr(4'd2, 1'b0, 0, -1);
    nextInstr(4'd0, 1'b0, 3, -1);
    nextInstr(4'd1, 1'b1, 0, -1);
    nextInstr(4'd11, 1'b1, 0, -1);
    nextInstr(4'd12, 1'b1, 0, -1);
    nextInstr(4'd11, 1'b0, 0, -1);
    nextInstr(4'd12, 1'b0, 0, -1);
    nextInstr(4'd13, 1'b0, 0, -1);
    nextInstr(4'd3, 1'b0, 0, 1);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      checkOutput("idleAfterStop", 32'(state), 32'd0);
      tick();
    end

    $display("[TB] random instruction stream");
    for (int n = 0; n < 40; n++) begin
      nextInstr(legalOps[$urandom_range(0, 12)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 4)),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    // Asynchronous reset in the middle of a load's memory wait.
    if (expState == 0) begin
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
    end
    checkOutput("preRstState", 32'(state), 32'd4);
    checkOutput("preRstMemRead", 32'(mem_read), 32'd1);
    checkOutput("preRstRetired", 32'(retired), 32'(expRetired));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midMemRstState", 32'(state), 32'd0);
    checkOutput("midMemRstStrobes", 32'(strobes), 32'd0);
    checkOutput("midMemRstRetired", 32'(retired), 32'd0);
    tick();
    rst_n      = 1'b1;
    expState   = 0;
    expRetired = '0;

    $display("[TB] traps");
    nextInstr(4'd15, 1'b0, 0, -1);
    trapHold(1'b1, 1'b0);
    nextInstr(4'd10, 1'b0, 0, -1);
    trapHold(1'b1, 1'b0);
    nextInstr(4'd14, 1'b0, 0, -1);
    trapHold(1'b1, 1'b0);
    nextInstr(4'd1, 1'b0, NEVER, -1);
    trapHold(1'b0, 1'b1);
    nextInstr(4'd0, 1'b0, NEVER, -1);
    trapHold(1'b0, 1'b1);
    doReset();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
